cache_control: RTL
==================

CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the hit and miss counters.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_read  input  1  CPU read request; held high until mem_resp.
REQ-005 SHALL have port mem_write  input  1  CPU write request; held high until mem_resp.
REQ-006 SHALL have port hit  input  2  per-way tag-match-and-valid from the datapath.
REQ-007 SHALL have port lru  input  1  LRU way of the indexed set.
REQ-008 SHALL have port lru_dirty  input  1  dirty AND valid of the LRU way.
REQ-009 SHALL have port pmem_resp  input  1  physical-memory completion strobe.
REQ-010 SHALL have port mem_resp  output  1  one-cycle CPU completion strobe.
REQ-011 SHALL have ports pmem_read and pmem_write  output  1 each  physical-memory requests.
REQ-012 SHALL have ports way_sel (waymux_sel_t), wdata_sel (wdatamux_sel_t), pmem_sel (pmemmux_sel_t) and wen_sel (write_enmux_sel_t)  output  datapath mux selects.
REQ-013 SHALL have ports load_tag, load_valid, load_dirty, dirty_in, load_lru, lru_in and load_data  output  1 each  array write controls.
REQ-014 SHALL have ports hit_count and miss_count  output  CNT_W each  saturating statistics counters.

Function
REQ-015 SHALL implement the states IDLE, COMPARE, WRITEBACK and ALLOCATE.
REQ-016 SHALL default, in every state, all load_*, dirty_in, lru_in, mem_resp and pmem_* outputs to 0, and way_sel=cmp, wdata_sel=wdata, pmem_sel=mem_address, wen_sel=cpu.
REQ-017 SHALL move from IDLE to COMPARE when mem_read|mem_write is high, and remain in IDLE otherwise.
REQ-018 SHALL, in COMPARE on hit!=0: assert mem_resp and load_lru for that cycle, with lru_in = the index of the way not hit; return to IDLE; increment hit_count.
REQ-019 SHALL, on a COMPARE write hit, additionally assert load_data, load_dirty and dirty_in=1 (wen_sel=cpu, wdata_sel=wdata).
REQ-020 SHALL treat hit==2'b11 as a way-0 hit.
REQ-021 SHALL, in COMPARE on hit==0: increment miss_count, and go to WRITEBACK if lru_dirty, else to ALLOCATE.
REQ-022 SHALL, in WRITEBACK: drive pmem_write=1, pmem_sel=tag, way_sel=lru; hold until pmem_resp, then go to ALLOCATE.
REQ-023 SHALL, in ALLOCATE: drive pmem_read=1, pmem_sel=mem_address, way_sel=lru.
REQ-024 SHALL, on pmem_resp in ALLOCATE: pulse load_data, load_tag, load_valid and load_dirty, with dirty_in=0, wen_sel=line and wdata_sel=line_o; then go to COMPARE, where the retried access hits.
REQ-025 SHALL never drive way_sel=mru.
REQ-026 SHALL ignore pmem_resp in IDLE and COMPARE.
REQ-027 SHALL count a miss once per miss, not on the COMPARE retry after a refill; the retry counts as neither a hit nor a miss.
REQ-028 SHALL saturate each counter at all-ones, with no wrap-around.
REQ-029 SHALL, on a write miss, count one miss and then perform a write hit on the retry.

Reset
REQ-030 SHALL, on rst_n low, immediately and asynchronously enter IDLE, clear both counters and the retry flag, and force all outputs to their REQ-016 defaults.
REQ-031 SHALL, on reset mid-WRITEBACK or mid-ALLOCATE, drop pmem_read/pmem_write in that same instant; no completion is owed to the CPU.

Structure
REQ-032 SHALL place the state enum cache_ctrl_state_t in new package cache_ctrl_types; the mux select types SHALL come from the existing packages wdatamux, waymux, pmemmux and write_enmux.
REQ-033 SHALL instantiate the sub-module sat_counter (parameter W, with inc input) twice, once per counter.
REQ-034 SHALL be a registered state plus a combinational output/next-state block, with no datapath storage.

Verification
REQ-035 SHALL cover: read with hit=2'b10 -> COMPARE one cycle after the request, mem_resp=1, load_lru=1, lru_in=0, hit_count=1.
REQ-036 SHALL cover: write with hit=2'b00, lru=1, lru_dirty=0, pmem_resp after 3 cycles -> pmem_read held 3 cycles; refill pulse with way_sel=lru, wen_sel=line; the retry then hits with hit=2'b10 and sets dirty_in=1 and mem_resp=1; miss_count=1, hit_count=0.
REQ-037 SHALL cover: read miss with lru_dirty=1 -> pmem_write with pmem_sel=tag until pmem_resp, then pmem_read with pmem_sel=mem_address; mem_resp exactly once.
REQ-038 SHALL cover: rst_n low during ALLOCATE -> pmem_read=0 before the next clk edge; state IDLE; counters 0.
REQ-039 SHALL cover: CNT_W=2 with 5 consecutive hits -> hit_count=3, no wrap.
REQ-040 SHALL cover: pmem_resp pulsed in IDLE -> no state change and no outputs asserted.

Source files
------------

// File: rtl/cache_ctrl_types.sv
// Shared types for the cache controller.
package cache_ctrl_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } cache_ctrl_state_t;

endpackage : cache_ctrl_types

// File: rtl/pmemmux.sv
// Physical-memory address mux select.
//   mem_address : CPU address (line fill)
//   tag         : address rebuilt from the stored tag (writeback)
package pmemmux;

  typedef enum logic {
    mem_address = 1'b0,
    tag         = 1'b1
  } pmemmux_sel_t;

endpackage : pmemmux

// File: rtl/waymux.sv
// Way mux select for the data/tag arrays.
//   cmp : way chosen by the tag comparison
//   lru : least-recently-used way of the set
//   mru : most-recently-used way of the set
package waymux;

  typedef enum logic [1:0] {
    cmp = 2'd0,
    lru = 2'd1,
    mru = 2'd2
  } waymux_sel_t;

endpackage : waymux

// File: rtl/wdatamux.sv
// Write-data mux select for the data array.
//   wdata  : CPU write data
//   line_o : refill line from physical memory
package wdatamux;

  typedef enum logic {
    wdata  = 1'b0,
    line_o = 1'b1
  } wdatamux_sel_t;

endpackage : wdatamux

// File: rtl/write_enmux.sv
// Data-array write-enable mux select.
//   cpu  : byte enables from the CPU
//   line : whole-line enable for a refill
package write_enmux;

  typedef enum logic {
    cpu  = 1'b0,
    line = 1'b1
  } write_enmux_sel_t;

endpackage : write_enmux

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears the count)
//   inc        : advance by one this cycle
//   count      : current value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule : sat_counter

// File: rtl/cache_control.sv
// Two-way write-back cache controller: lookup, dirty-victim writeback,
// line allocate and retry, plus saturating hit/miss statistics.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   mem_read, mem_write   : CPU request, held until mem_resp
//   hit                   : per-way tag match AND valid
//   lru, lru_dirty        : LRU way of the set and its dirty AND valid
//   pmem_resp             : physical-memory completion strobe
//   mem_resp              : one-cycle CPU completion
//   pmem_read, pmem_write : physical-memory requests
//   way_sel .. wen_sel    : datapath mux selects
//   load_* , dirty_in, lru_in : array write controls
//   hit_count, miss_count : saturating statistics
module cache_control
  import cache_ctrl_types::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_read,
  input  logic                         mem_write,
  input  logic [1:0]                   hit,
  input  logic                         lru,
  input  logic                         lru_dirty,
  input  logic                         pmem_resp,
  output logic                         mem_resp,
  output logic                         pmem_read,
  output logic                         pmem_write,
  output waymux::waymux_sel_t          way_sel,
  output wdatamux::wdatamux_sel_t      wdata_sel,
  output pmemmux::pmemmux_sel_t        pmem_sel,
  output write_enmux::write_enmux_sel_t wen_sel,
  output logic                         load_tag,
  output logic                         load_valid,
  output logic                         load_dirty,
  output logic                         dirty_in,
  output logic                         load_lru,
  output logic                         lru_in,
  output logic                         load_data,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count
);

  cache_ctrl_state_t r_state;
  cache_ctrl_state_t w_state_next;
  logic              r_retry;
  logic              w_retry_next;
  logic              w_hit_inc;
  logic              w_miss_inc;

  // The LRU way value is consumed by the datapath way mux, not here.
  logic w_unused_lru;
  assign w_unused_lru = lru;

  // State and retry-after-refill flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_retry <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_retry <= w_retry_next;
    end
  end

  // Next state and datapath controls.
  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    w_hit_inc    = 1'b0;
    w_miss_inc   = 1'b0;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    way_sel      = waymux::cmp;
    wdata_sel    = wdatamux::wdata;
    pmem_sel     = pmemmux::mem_address;
    wen_sel      = write_enmux::cpu;
    load_tag     = 1'b0;
    load_valid   = 1'b0;
    load_dirty   = 1'b0;
    dirty_in     = 1'b0;
    load_lru     = 1'b0;
    lru_in       = 1'b0;
    load_data    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (mem_read || mem_write) begin
          w_state_next = COMPARE;
        end
      end

      COMPARE: begin
        w_retry_next = 1'b0;
        if (hit != 2'b00) begin
          mem_resp = 1'b1;
          load_lru = 1'b1;
          // Way 0 wins a double match, so the other way becomes LRU.
          lru_in   = hit[0];
          if (mem_write) begin
            load_data  = 1'b1;
            load_dirty = 1'b1;
            dirty_in   = 1'b1;
          end
          // The post-refill retry is part of the original miss.
          w_hit_inc    = ~r_retry;
          w_state_next = IDLE;
        end else begin
          w_miss_inc   = ~r_retry;
          w_state_next = lru_dirty ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_sel   = pmemmux::tag;
        way_sel    = waymux::lru;
        if (pmem_resp) begin
          w_state_next = ALLOCATE;
        end
      end

      ALLOCATE: begin
        pmem_read = 1'b1;
        way_sel   = waymux::lru;
        if (pmem_resp) begin
          load_data    = 1'b1;
          load_tag     = 1'b1;
          load_valid   = 1'b1;
          load_dirty   = 1'b1;
          wen_sel      = write_enmux::line;
          wdata_sel    = wdatamux::line_o;
          w_retry_next = 1'b1;
          w_state_next = COMPARE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hit_inc),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_miss_inc),
    .count (miss_count)
  );

endmodule : cache_control
